// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB bridge: each accepted AHB transfer becomes one APB transfer,
// with 4-bit slot decode, wait-state timeout and registered bus outputs.
module ahb2apb_bridge #(
    parameter int unsigned NUM_SLAVES = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SLOT_LSB   = 24,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SLOT_W = 4;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic                  hwrite_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic                  penable_q;
    logic [31:0]           pwdata_q;
    logic [31:0]           hrdata_q;
    logic                  hreadyout_q;
    logic                  hresp_q;

    logic accept_c;
    logic slot_ok_c;
    logic timeout_c;
    logic unused_c;

    assign accept_c  = HSEL & HREADYIN & HTRANS[1];
    assign slot_ok_c = (32'(slot_q) < NUM_SLAVES);
    assign timeout_c = TIMEOUT_EN && (cnt_q == TIMEOUT_CNT);
    assign unused_c  = ^{HSIZE, HTRANS[0], HADDR};

    // Next state and wait counter; new address phases only land in ready states
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR2: state_d = accept_c ? S_LATCH : S_IDLE;
            S_LATCH:                state_d = slot_ok_c ? S_SETUP : S_ERR1;
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = '0;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    state_d = PSLVERR ? S_ERR1 : S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (timeout_c) begin
                        state_d = S_ERR1;
                    end
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // One-hot slot select, only while the APB transfer is live
    always_comb begin
        psel_d = '0;
        if (state_d == S_SETUP || state_d == S_ACCESS) begin
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                psel_d[i] = (slot_q == SLOT_W'(i));
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            slot_q      <= '0;
            cnt_q       <= '0;
            psel_q      <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_d == S_LATCH) begin
                haddr_q  <= HADDR[ADDR_WIDTH-1:0];
                hwrite_q <= HWRITE;
                slot_q   <= HADDR[SLOT_LSB+SLOT_W-1:SLOT_LSB];
            end
            // Write data arrives in the AHB data phase, which is the LATCH cycle
            if (state_q == S_LATCH && hwrite_q) begin
                pwdata_q <= HWDATA;
            end
            if (state_d == S_SETUP) begin
                paddr_q  <= haddr_q;
                pwrite_q <= hwrite_q;
            end
            if (state_q == S_ACCESS && state_d == S_DONE && !hwrite_q) begin
                hrdata_q <= PRDATA;
            end
            psel_q      <= psel_d;
            penable_q   <= (state_d == S_ACCESS);
            hreadyout_q <= (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR2);
            hresp_q     <= (state_d == S_ERR1) || (state_d == S_ERR2);
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRDATA    = hrdata_q;
    assign HRESP     = hresp_q;
    assign PSEL      = psel_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PENABLE   = penable_q;
    assign PWDATA    = pwdata_q;

endmodule
